// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared constants and helpers for the lfsr_gen family.
//   - LFSR_TAPS_<n>: maximal-length feedback tap masks for widths 3..32.
//     Bit k of a mask selects state bit k. The feedback is XNORed into bit 0
//     while the register shifts toward the MSB.
//   - all_ones(width): 32-bit word with the low 'width' bits set.
package lfsr_pkg;

  localparam logic [2:0]  LFSR_TAPS_3  = 3'h6;
  localparam logic [3:0]  LFSR_TAPS_4  = 4'hC;
  localparam logic [4:0]  LFSR_TAPS_5  = 5'h14;
  localparam logic [5:0]  LFSR_TAPS_6  = 6'h30;
  localparam logic [6:0]  LFSR_TAPS_7  = 7'h60;
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [8:0]  LFSR_TAPS_9  = 9'h110;
  localparam logic [9:0]  LFSR_TAPS_10 = 10'h240;
  localparam logic [10:0] LFSR_TAPS_11 = 11'h500;
  localparam logic [11:0] LFSR_TAPS_12 = 12'h829;
  localparam logic [12:0] LFSR_TAPS_13 = 13'h100D;
  localparam logic [13:0] LFSR_TAPS_14 = 14'h2015;
  localparam logic [14:0] LFSR_TAPS_15 = 15'h6000;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hD008;
  localparam logic [16:0] LFSR_TAPS_17 = 17'h12000;
  localparam logic [17:0] LFSR_TAPS_18 = 18'h20400;
  localparam logic [18:0] LFSR_TAPS_19 = 19'h40023;
  localparam logic [19:0] LFSR_TAPS_20 = 20'h90000;
  localparam logic [20:0] LFSR_TAPS_21 = 21'h140000;
  localparam logic [21:0] LFSR_TAPS_22 = 22'h300000;
  localparam logic [22:0] LFSR_TAPS_23 = 23'h420000;
  localparam logic [23:0] LFSR_TAPS_24 = 24'hE10000;
  localparam logic [24:0] LFSR_TAPS_25 = 25'h1200000;
  localparam logic [25:0] LFSR_TAPS_26 = 26'h2000023;
  localparam logic [26:0] LFSR_TAPS_27 = 27'h4000013;
  localparam logic [27:0] LFSR_TAPS_28 = 28'h9000000;
  localparam logic [28:0] LFSR_TAPS_29 = 29'h14000000;
  localparam logic [29:0] LFSR_TAPS_30 = 30'h20000029;
  localparam logic [30:0] LFSR_TAPS_31 = 31'h48000000;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

  function automatic logic [31:0] all_ones(input int unsigned width);
    if (width >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/lfsr_period_tracker.sv
// lfsr_period_tracker: remembers the anchor state (seed after reset/recovery,
// or the last loaded value), counts advances since the anchor and pulses
// period_wrap_o for one cycle when an advance lands back on the anchor.
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-low reset (anchor=SEED, count=0)
//   load_i        parallel load this edge; anchor takes load_val_i
//   load_val_i    value being loaded
//   recover_i     lock-up recovery this edge; anchor returns to SEED
//   adv_i         ordinary advance this edge (never with load/recovery)
//   next_state_i  state the LFSR takes at this edge
//   period_wrap_o registered one-cycle wrap pulse
module lfsr_period_tracker #(
  parameter int unsigned      WIDTH = 10,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             recover_i,
  input  logic             adv_i,
  input  logic [WIDTH-1:0] next_state_i,
  output logic             period_wrap_o
);

  logic [WIDTH-1:0] anchor_q, anchor_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    anchor_d = anchor_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    if (load_i || recover_i) begin
      anchor_d = load_i ? load_val_i : SEED;
      cnt_d    = '0;
    end else if (adv_i) begin
      if (next_state_i == anchor_q) begin
        wrap_d = 1'b1;
        cnt_d  = '0;
      end else begin
        // Free-running WIDTH-bit count; wraps silently for non-maximal taps.
        cnt_d = cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anchor_q <= SEED;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      anchor_q <= anchor_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
    end
  end

  assign period_wrap_o = wrap_q;

endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised XNOR Fibonacci LFSR used as the pseudo-random source
// for the computer player, with advance enable, parallel load, a registered
// "press" comparator, period-wrap detection and optional lock-up recovery.
// Optional feature macro: LFSR_GEN_LOCKUP_RECOVER_EN (all-ones recovery).
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   en           advance one step this edge
//   load         load load_val this edge (wins over en)
//   load_val     value for load
//   thresh       comparator threshold
//   out          current LFSR state
//   fire         registered: out value taken at the edge < thresh (unsigned)
//   period_wrap  one-cycle pulse: an advance returned to the anchor value
//   lockup       sticky: all-ones state was recovered (0 without the macro)
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned      WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_10,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] thresh,
  output logic [WIDTH-1:0] out,
  output logic             fire,
  output logic             period_wrap,
  output logic             lockup
);

  localparam logic [31:0]      ONES32 = all_ones(WIDTH);
  localparam logic [WIDTH-1:0] ONES   = ONES32[WIDTH-1:0];

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_gen: WIDTH must be in 3..32");
  end
  if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps
    $error("lfsr_gen: TAPS must include bit WIDTH-1");
  end
  if (SEED == ONES) begin : g_bad_seed
    $error("lfsr_gen: SEED must not be all-ones (XNOR lock-up state)");
  end

  logic [WIDTH-1:0] out_q, out_d;
  logic             fire_q, fire_d;
  logic             fb;
  logic [WIDTH-1:0] adv_val;
  logic             recover;

  // XNOR feedback: the all-zeros state is legal, all-ones is the fixed point.
  assign fb      = ~^(out_q & TAPS);
  assign adv_val = {out_q[WIDTH-2:0], fb};

  always_comb begin
    out_d   = out_q;
    recover = 1'b0;
    if (load) begin
      out_d = load_val;
    end else if (en) begin
`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
      if (out_q == ONES) begin
        out_d   = SEED;
        recover = 1'b1;
      end else begin
        out_d = adv_val;
      end
`else
      out_d = adv_val;
`endif
    end
    // Compare against the value out is about to take, so fire lines up with out.
    fire_d = (out_d < thresh);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q  <= SEED;
      fire_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      fire_q <= fire_d;
    end
  end

`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
  logic lockup_q, lockup_d;

  assign lockup_d = lockup_q | recover;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lockup_q <= 1'b0;
    else        lockup_q <= lockup_d;
  end

  assign lockup = lockup_q;
`else
  assign lockup = 1'b0;
`endif

  lfsr_period_tracker #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_tracker (
    .clk           (clk),
    .reset         (reset),
    .load_i        (load),
    .load_val_i    (load_val),
    .recover_i     (recover),
    .adv_i         (en & ~load & ~recover),
    .next_state_i  (out_d),
    .period_wrap_o (period_wrap)
  );

  assign out  = out_q;
  assign fire = fire_q;

endmodule

// File: tb/tb_lfsr_gen.sv
module tb_lfsr_gen;

  logic       clk;
  logic       reset;
  logic       en;
  logic       load;
  logic [9:0] load_val;
  logic [9:0] thresh;
  logic [9:0] out;
  logic       fire;
  logic       period_wrap;
  logic       lockup;

  int n_chk;
  int n_fail;

  lfsr_gen #(
    .WIDTH (10),
    .TAPS  (10'h240),
    .SEED  (10'h000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .load        (load),
    .load_val    (load_val),
    .thresh      (thresh),
    .out         (out),
    .fire        (fire),
    .period_wrap (period_wrap),
    .lockup      (lockup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       ld;
    logic       en;
    logic [9:0] val;
    logic [9:0] th;
    logic [9:0] eout;
    logic       efire;
    logic       ewrap;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    int wraps;
    int wrap_at;
    logic [9:0] wrap_out;

    n_chk = 0;
    n_fail = 0;
    reset = 1'b0;
    en = 1'b0;
    load = 1'b0;
    load_val = '0;
    thresh = '0;

    // {load, en, load_val, thresh, out, fire, period_wrap}
    tbl[0] = '{1'b0, 1'b1, 10'h000, 10'h004, 10'h001, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 10'h000, 10'h004, 10'h003, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 10'h000, 10'h004, 10'h007, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 10'h000, 10'h008, 10'h007, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 10'h155, 10'h000, 10'h155, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 10'h000, 10'h3FF, 10'h2AA, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 10'h000, 10'h100, 10'h154, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 10'h000, 10'h001, 10'h000, 1'b1, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 10'h3FF, 10'h000, 10'h000, 1'b0, 1'b0};

    #12;
    chk("rst_out", 32'(out), 32'h000);
    chk("rst_fire", 32'(fire), 32'h0);
    chk("rst_wrap", 32'(period_wrap), 32'h0);
    chk("rst_lockup", 32'(lockup), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      load = tbl[i].ld;
      en = tbl[i].en;
      load_val = tbl[i].val;
      thresh = tbl[i].th;
      tick();
      chk($sformatf("vec%0d_out", i), 32'(out), 32'(tbl[i].eout));
      chk($sformatf("vec%0d_fire", i), 32'(fire), 32'(tbl[i].efire));
      chk($sformatf("vec%0d_wrap", i), 32'(period_wrap), 32'(tbl[i].ewrap));
      chk($sformatf("vec%0d_lockup", i), 32'(lockup), 32'h0);
    end

    // Full period from the reset seed.
    load = 1'b0;
    en = 1'b1;
    thresh = '0;
    pulse_reset();
    wraps = 0;
    wrap_at = 0;
    wrap_out = '1;
    for (int i = 1; i <= 1023; i++) begin
      tick();
      if (period_wrap) begin
        wraps++;
        wrap_at = i;
        wrap_out = out;
      end
    end
    chk("seed_wrap_count", 32'(wraps), 32'd1);
    chk("seed_wrap_edge", 32'(wrap_at), 32'd1023);
    chk("seed_wrap_out", 32'(wrap_out), 32'h000);

    // Load with en: load wins, then the period is measured from the loaded value.
    tick();
    chk("post_wrap_clear", 32'(period_wrap), 32'h0);
    load = 1'b1;
    load_val = 10'h155;
    en = 1'b1;
    tick();
    chk("load_out", 32'(out), 32'h155);
    chk("load_wrap", 32'(period_wrap), 32'h0);
    load = 1'b0;
    wraps = 0;
    wrap_at = 0;
    wrap_out = '0;
    for (int i = 1; i <= 1023; i++) begin
      tick();
      if (period_wrap) begin
        wraps++;
        wrap_at = i;
        wrap_out = out;
      end
    end
    chk("load_wrap_count", 32'(wraps), 32'd1);
    chk("load_wrap_edge", 32'(wrap_at), 32'd1023);
    chk("load_wrap_out", 32'(wrap_out), 32'h155);

    // All-ones lock-up state.
    load = 1'b1;
    load_val = 10'h3FF;
    en = 1'b0;
    tick();
    chk("ones_load_out", 32'(out), 32'h3FF);
    chk("ones_load_lockup", 32'(lockup), 32'h0);
    load = 1'b0;
    en = 1'b1;
`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
    tick();
    chk("recover_out", 32'(out), 32'h000);
    chk("recover_lockup", 32'(lockup), 32'h1);
    chk("recover_wrap", 32'(period_wrap), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("recover_hold%0d", i), 32'(lockup), 32'h1);
    end
`else
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("ones_out%0d", i), 32'(out), 32'h3FF);
      chk($sformatf("ones_lockup%0d", i), 32'(lockup), 32'h0);
      chk($sformatf("ones_wrap%0d", i), 32'(period_wrap), 32'h1);
    end
`endif

    // Asynchronous reset between edges.
    load = 1'b1;
    load_val = 10'h100;
    en = 1'b0;
    thresh = 10'h3FF;
    tick();
    load = 1'b0;
    en = 1'b1;
    tick();
    tick();
    chk("pre_rst_out", 32'(out), 32'h002);
    chk("pre_rst_fire", 32'(fire), 32'h1);
    reset = 1'b0;
    #2;
    chk("async_rst_out", 32'(out), 32'h000);
    chk("async_rst_fire", 32'(fire), 32'h0);
    chk("async_rst_wrap", 32'(period_wrap), 32'h0);
    chk("async_rst_lockup", 32'(lockup), 32'h0);
    #1;
    reset = 1'b1;
    tick();
    chk("restart_out", 32'(out), 32'h001);
    tick();
    chk("restart_out2", 32'(out), 32'h003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
